// File: rtl/product_display_if.sv
// product_display_if: groups the request/result signals of product_display.
//   load, value, error      : requester -> display (convert request, operand, error level)
//   HEX0..HEX5               : display -> board, active-low {dp,g,f,e,d,c,b,a}
//   busy, done, ovf          : display -> requester status
// master modport is the requesting side, slave modport is product_display.
interface product_display_if;
    logic        load;
    logic [15:0] value;
    logic        error;
    logic [7:0]  HEX0;
    logic [7:0]  HEX1;
    logic [7:0]  HEX2;
    logic [7:0]  HEX3;
    logic [7:0]  HEX4;
    logic [7:0]  HEX5;
    logic        busy;
    logic        done;
    logic        ovf;

    modport master (
        output load, value, error,
        input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, done, ovf
    );

    modport slave (
        input  load, value, error,
        output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, busy, done, ovf
    );
endinterface

// File: rtl/product_display.sv
// product_display: converts a 16-bit unsigned product to four BCD digits with a
// sequential double-dabble (one iteration per clock) and shows them on HEX3..HEX0.
// Latency from an accepted load to updated displays and the done pulse is 17 cycles.
// Values above 9999 show dashes and raise ovf. While error is high HEX0..HEX3 show
// all segments lit; the latched digits come back when error falls. HEX4/HEX5 blank.
//
// Ports:
//   MAX10_CLK1_50 : system clock, rising edge
//   KEY1          : asynchronous active-low reset
//   bus (slave)   : load/value/error in; HEX0..HEX5, busy, done, ovf out
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits on
// HEX3..HEX1 (HEX0 always shows its digit).
module product_display (
    input  logic             MAX10_CLK1_50,
    input  logic             KEY1,
    product_display_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] LATCH = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_ALL   = 8'h00;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] UPPER_RST = SEG_BLANK;
`else
    localparam logic [7:0] UPPER_RST = SEG_ZERO;
`endif

    logic [1:0]  state;
    logic [15:0] shreg;
    logic [15:0] digits;
    logic [4:0]  cnt;
    logic        big;
    logic        err_q;
    logic        done_q;
    logic        ovf_q;
    logic [7:0]  hex0_q, hex1_q, hex2_q, hex3_q;

    logic [15:0] digits_adj;
    logic [7:0]  hex0_nxt, hex1_nxt, hex2_nxt, hex3_nxt;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 8'hC0;
            4'd1:    seg7 = 8'hF9;
            4'd2:    seg7 = 8'hA4;
            4'd3:    seg7 = 8'hB0;
            4'd4:    seg7 = 8'h99;
            4'd5:    seg7 = 8'h92;
            4'd6:    seg7 = 8'h82;
            4'd7:    seg7 = 8'hF8;
            4'd8:    seg7 = 8'h80;
            4'd9:    seg7 = 8'h90;
            default: seg7 = SEG_DASH;
        endcase
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] d);
        dabble = (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Add-3 correction applied to every digit before the shift.
    always_comb begin
        digits_adj = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            digits_adj[i*4 +: 4] = dabble(digits[i*4 +: 4]);
        end
    end

    always_comb begin
        hex0_nxt = seg7(digits[3:0]);
        hex1_nxt = seg7(digits[7:4]);
        hex2_nxt = seg7(digits[11:8]);
        hex3_nxt = seg7(digits[15:12]);
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is blanked only when it and every higher digit are zero.
        if (digits[15:12] == 4'd0) begin
            hex3_nxt = SEG_BLANK;
            if (digits[11:8] == 4'd0) begin
                hex2_nxt = SEG_BLANK;
                if (digits[7:4] == 4'd0) begin
                    hex1_nxt = SEG_BLANK;
                end
            end
        end
`endif
        if (big) begin
            hex0_nxt = SEG_DASH;
            hex1_nxt = SEG_DASH;
            hex2_nxt = SEG_DASH;
            hex3_nxt = SEG_DASH;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge KEY1) begin
        if (!KEY1) begin
            state  <= IDLE;
            shreg  <= '0;
            digits <= '0;
            cnt    <= '0;
            big    <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            hex0_q <= SEG_ZERO;
            hex1_q <= UPPER_RST;
            hex2_q <= UPPER_RST;
            hex3_q <= UPPER_RST;
        end else begin
            err_q  <= bus.error;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        shreg  <= bus.value;
                        digits <= '0;
                        cnt    <= '0;
                        big    <= (bus.value > 16'd9999);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {digits, shreg} <= {digits_adj[14:0], shreg, 1'b0};
                    cnt             <= cnt + 5'd1;
                    if (cnt == 5'd15) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    hex0_q <= hex0_nxt;
                    hex1_q <= hex1_nxt;
                    hex2_q <= hex2_nxt;
                    hex3_q <= hex3_nxt;
                    ovf_q  <= big;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.HEX0 = err_q ? SEG_ALL : hex0_q;
    assign bus.HEX1 = err_q ? SEG_ALL : hex1_q;
    assign bus.HEX2 = err_q ? SEG_ALL : hex2_q;
    assign bus.HEX3 = err_q ? SEG_ALL : hex3_q;
    assign bus.HEX4 = SEG_BLANK;
    assign bus.HEX5 = SEG_BLANK;
    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.ovf  = ovf_q;

endmodule
